// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   state_e    : sequencer states (IDLE=0, ACCESS=1)
//   REQ0/REQ1  : requester index constants used for owner and priority pointer
package mem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters / memory and the arbiter.
//   requester side : reqN, weN, addrN, wdataN in; gntN, doneN, errN, rdataN out
//   memory side    : mem_read_address, mem_write_address, mem_write_data,
//                    mem_write_enable out; mem_read_data in (combinational)
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus memory)
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;

    logic                  gnt0;
    logic                  gnt1;
    logic                  done0;
    logic                  done1;
    logic                  err0;
    logic                  err1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;

    logic [ADDR_WIDTH-1:0] mem_read_address;
    logic [ADDR_WIDTH-1:0] mem_write_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_write_enable;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
               mem_read_address, mem_write_address, mem_write_data, mem_write_enable
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
               mem_read_address, mem_write_address, mem_write_data, mem_write_enable
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin winner select with its priority pointer.
//   clock, reset : rising-edge clock, async active-low reset (pointer -> REQ0)
//   req0, req1   : pending requests
//   advance      : a grant is taken this cycle; pointer moves to the loser
//   any_req_c    : at least one request pending (combinational)
//   winner_c     : index of the requester that wins (combinational)
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic any_req_c,
    output logic winner_c
);

    logic ptr_q;
    logic ptr_d;

    // Sole requester wins outright; on contention the pointer decides.
    always_comb begin
        any_req_c = req0 | req1;
        winner_c  = REQ0;
        if (req0 && req1) begin
            winner_c = ptr_q;
        end else if (req1) begin
            winner_c = REQ1;
        end
        ptr_d = advance ? ~winner_c : ptr_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= REQ0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer in front of a single-port-pair memory.
//   clock, reset : rising-edge clock, async active-low reset
//   bus          : requester handshakes and memory-side address/data/enable
// One access per two cycles: IDLE latches the winner and drives the memory,
// ACCESS returns done/err/rdata to the owner. Every output is a flop.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CELL_COUNT = 4
) (
    input  logic           clock,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);

    localparam logic [ADDR_WIDTH-1:0] CELL_LIMIT = ADDR_WIDTH'(CELL_COUNT);

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  is_write_q, is_write_d;
    logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                  done0_q, done0_d, done1_q, done1_d;
    logic                  err0_q, err0_d, err1_q, err1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [ADDR_WIDTH-1:0] mem_ra_q, mem_ra_d, mem_wa_q, mem_wa_d;
    logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
    logic                  mem_we_q, mem_we_d;

    logic                  any_req_c;
    logic                  winner_c;
    logic                  advance_c;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  addr_err;
    logic [DATA_WIDTH-1:0] rd_val;

    rr_arbiter2 u_rr (
        .clock     (clock),
        .reset     (reset),
        .req0      (bus.req0),
        .req1      (bus.req1),
        .advance   (advance_c),
        .any_req_c (any_req_c),
        .winner_c  (winner_c)
    );

    // Next-state and output computation.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        is_write_d = is_write_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        mem_ra_d   = mem_ra_q;
        mem_wa_d   = mem_wa_q;
        mem_wd_d   = mem_wd_q;
        mem_we_d   = 1'b0;
        advance_c  = 1'b0;

        sel_we    = (winner_c == REQ1) ? bus.we1    : bus.we0;
        sel_addr  = (winner_c == REQ1) ? bus.addr1  : bus.addr0;
        sel_wdata = (winner_c == REQ1) ? bus.wdata1 : bus.wdata0;

        // The latched write address doubles as the owner's request address.
        addr_err = (mem_wa_q >= CELL_LIMIT);
        rd_val   = (is_write_q || addr_err) ? '0 : bus.mem_read_data;

        case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    advance_c  = 1'b1;
                    state_d    = ST_ACCESS;
                    owner_d    = winner_c;
                    is_write_d = sel_we;
                    gnt0_d     = (winner_c == REQ0);
                    gnt1_d     = (winner_c == REQ1);
                    mem_ra_d   = sel_addr;
                    mem_wa_d   = sel_addr;
                    mem_wd_d   = sel_wdata;
                    // Out-of-range writes never reach the memory.
                    mem_we_d   = sel_we && (sel_addr < CELL_LIMIT);
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                if (owner_q == REQ0) begin
                    done0_d  = 1'b1;
                    err0_d   = addr_err;
                    rdata0_d = rd_val;
                end else begin
                    done1_d  = 1'b1;
                    err1_d   = addr_err;
                    rdata1_d = rd_val;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= REQ0;
            is_write_q <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            mem_ra_q   <= '0;
            mem_wa_q   <= '0;
            mem_wd_q   <= '0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            is_write_q <= is_write_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            mem_ra_q   <= mem_ra_d;
            mem_wa_q   <= mem_wa_d;
            mem_wd_q   <= mem_wd_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign bus.gnt0              = gnt0_q;
    assign bus.gnt1              = gnt1_q;
    assign bus.done0             = done0_q;
    assign bus.done1             = done1_q;
    assign bus.err0              = err0_q;
    assign bus.err1              = err1_q;
    assign bus.rdata0            = rdata0_q;
    assign bus.rdata1            = rdata1_q;
    assign bus.mem_read_address  = mem_ra_q;
    assign bus.mem_write_address = mem_wa_q;
    assign bus.mem_write_data    = mem_wd_q;
    assign bus.mem_write_enable  = mem_we_q;

endmodule
